// File: rtl/gcm_tag_finalize.sv
// GCM tag finalisation: folds the length block into the GHASH state, multiplies by H
// with an iterative GF(2^128) slice, then XORs E(K,J0) to form or verify the tag.
module gcm_tag_finalize #(
    parameter int BITS_PER_CYCLE = 8,
    parameter int NUM_CH         = 4,
    parameter int TAG_BYTES      = 16,
    localparam int CHW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [CHW-1:0]  i_ch,
    input  logic [0:127]    i_sblock,
    input  logic [0:127]    i_instance_size,
    input  logic [0:127]    i_h,
    input  logic [0:127]    i_encrypted_j0,
    input  logic            i_mode,
    input  logic [0:127]    i_ref_tag,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [CHW-1:0]  o_ch,
    output logic [0:127]    o_tag,
    output logic            o_auth_ok,
    output logic            o_auth_fail
);

    localparam int N    = 128 / BITS_PER_CYCLE;
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:127] GF_R     = 128'he1000000000000000000000000000000;
    localparam logic [0:127] TAG_MASK = {128{1'b1}} << (128 - 8 * TAG_BYTES);

    if ((BITS_PER_CYCLE < 1) || ((128 % BITS_PER_CYCLE) != 0)) begin : g_bad_bpc
        $error("gcm_tag_finalize: BITS_PER_CYCLE must divide 128");
    end
    if ((TAG_BYTES < 12) || (TAG_BYTES > 16)) begin : g_bad_tag
        $error("gcm_tag_finalize: TAG_BYTES must be in 12..16");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [0:127]      r_x;
    logic [0:127]      r_v;
    logic [0:127]      r_z;
    logic [0:127]      r_e;
    logic [0:127]      r_ref;
    logic              r_mode;
    logic [CHW-1:0]    r_ch;
    logic [CNTW-1:0]   r_cnt;

    logic [0:127]      w_z_next;
    logic [0:127]      w_v_next;
    logic [0:127]      w_t;
    logic              w_match;
    logic              w_last;

    assign o_ready = (r_state == ST_IDLE) & ~rst;

    // One multiplier slice: consume BITS_PER_CYCLE bits of X, MSB (index 0) first.
    always_comb begin
        w_z_next = r_z;
        w_v_next = r_v;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_x[i]) begin
                w_z_next = w_z_next ^ w_v_next;
            end else begin
                w_z_next = w_z_next;
            end
            if (w_v_next[127]) begin
                w_v_next = (w_v_next >> 7'd1) ^ GF_R;
            end else begin
                w_v_next = w_v_next >> 7'd1;
            end
        end
    end

    // Final tag, truncated comparison against the reference and last-slice detect.
    always_comb begin
        w_t     = w_z_next ^ r_e;
        w_match = (((w_t ^ r_ref) & TAG_MASK) == 128'd0);
        w_last  = (r_cnt == CNTW'(N - 1));
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_x         <= 128'd0;
            r_v         <= 128'd0;
            r_z         <= 128'd0;
            r_e         <= 128'd0;
            r_ref       <= 128'd0;
            r_mode      <= 1'b0;
            r_ch        <= '0;
            r_cnt       <= '0;
            o_valid     <= 1'b0;
            o_ch        <= '0;
            o_tag       <= 128'd0;
            o_auth_ok   <= 1'b0;
            o_auth_fail <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid && o_ready) begin
                        r_x     <= i_sblock ^ i_instance_size;
                        r_v     <= i_h;
                        r_z     <= 128'd0;
                        r_e     <= i_encrypted_j0;
                        r_ref   <= i_ref_tag;
                        r_mode  <= i_mode;
                        r_ch    <= i_ch;
                        r_cnt   <= '0;
                        r_state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_z   <= w_z_next;
                    r_v   <= w_v_next;
                    r_x   <= r_x << BITS_PER_CYCLE;
                    r_cnt <= r_cnt + CNTW'(1);
                    if (w_last) begin
                        // Verify mode never exposes the computed tag.
                        o_tag       <= r_mode ? 128'd0 : (w_t & TAG_MASK);
                        o_auth_ok   <= r_mode & w_match;
                        o_auth_fail <= r_mode & ~w_match;
                        o_ch        <= r_ch;
                        o_valid     <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid     <= 1'b0;
                        o_auth_ok   <= 1'b0;
                        o_auth_fail <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcm_tag_finalize.sv
// Scoreboard bench for gcm_tag_finalize across slice widths, tag truncation and verify mode.
module tb_gcm_tag_finalize;

    localparam logic [0:127] H_C    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [0:127] EJ0_C  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [0:127] SB2_C  = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [0:127] LEN2_C = 128'h00000000000000000000000000000080;
    localparam logic [0:127] TAG2_C = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam logic [0:127] ONE_C  = 128'h80000000000000000000000000000000;
    localparam logic [0:127] R_C    = 128'he1000000000000000000000000000000;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   i_ch;
    logic [0:127] sblock, len, h, ej0, reft;
    logic         mode;

    logic         vld[4], rdy[4], ovld[4], irdy[4], aok[4], afail[4];
    logic [1:0]   och[4];
    logic [0:127] otag[4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat_of[4] = '{16, 128, 1, 16};

    typedef struct {
        logic [0:127] tag;
        logic         ok;
        logic         fail;
        logic [1:0]   ch;
        int           lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcm_tag_finalize #(.BITS_PER_CYCLE(8), .NUM_CH(4), .TAG_BYTES(16)) u_bpc8 (
        .clk(clk), .rst(rst), .i_valid(vld[0]), .o_ready(rdy[0]), .i_ch(i_ch),
        .i_sblock(sblock), .i_instance_size(len), .i_h(h), .i_encrypted_j0(ej0),
        .i_mode(mode), .i_ref_tag(reft), .o_valid(ovld[0]), .i_ready(irdy[0]),
        .o_ch(och[0]), .o_tag(otag[0]), .o_auth_ok(aok[0]), .o_auth_fail(afail[0]));
    gcm_tag_finalize #(.BITS_PER_CYCLE(1), .NUM_CH(4), .TAG_BYTES(16)) u_bpc1 (
        .clk(clk), .rst(rst), .i_valid(vld[1]), .o_ready(rdy[1]), .i_ch(i_ch),
        .i_sblock(sblock), .i_instance_size(len), .i_h(h), .i_encrypted_j0(ej0),
        .i_mode(mode), .i_ref_tag(reft), .o_valid(ovld[1]), .i_ready(irdy[1]),
        .o_ch(och[1]), .o_tag(otag[1]), .o_auth_ok(aok[1]), .o_auth_fail(afail[1]));
    gcm_tag_finalize #(.BITS_PER_CYCLE(128), .NUM_CH(4), .TAG_BYTES(16)) u_bpc128 (
        .clk(clk), .rst(rst), .i_valid(vld[2]), .o_ready(rdy[2]), .i_ch(i_ch),
        .i_sblock(sblock), .i_instance_size(len), .i_h(h), .i_encrypted_j0(ej0),
        .i_mode(mode), .i_ref_tag(reft), .o_valid(ovld[2]), .i_ready(irdy[2]),
        .o_ch(och[2]), .o_tag(otag[2]), .o_auth_ok(aok[2]), .o_auth_fail(afail[2]));
    gcm_tag_finalize #(.BITS_PER_CYCLE(8), .NUM_CH(4), .TAG_BYTES(12)) u_tag12 (
        .clk(clk), .rst(rst), .i_valid(vld[3]), .o_ready(rdy[3]), .i_ch(i_ch),
        .i_sblock(sblock), .i_instance_size(len), .i_h(h), .i_encrypted_j0(ej0),
        .i_mode(mode), .i_ref_tag(reft), .o_valid(ovld[3]), .i_ready(irdy[3]),
        .o_ch(och[3]), .o_tag(otag[3]), .o_auth_ok(aok[3]), .o_auth_fail(afail[3]));

    // Bit-serial reference GF(2^128) product, bit 0 = MSB.
    function automatic logic [0:127] gmul(input logic [0:127] x, input logic [0:127] y);
        logic [0:127] z;
        logic [0:127] v;
        z = 128'd0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[i]) z = z ^ v;
            if (v[127]) v = (v >> 1) ^ R_C;
            else        v = v >> 1;
        end
        return z;
    endfunction

    // Drive one request into DUT d, scramble inputs after accept, wait for the result.
    task automatic issue(input int d, input logic [0:127] s, l, hh, e, r, input logic m,
                         input logic [1:0] c, output logic [0:127] tag, output logic ok,
                         output logic fl, output logic [1:0] ch, output int lat, output int acc);
        int w;
        @(negedge clk);
        sblock = s; len = l; h = hh; ej0 = e; reft = r; mode = m; i_ch = c;
        vld[d] = 1'b1;
        w = 0;
        while (!rdy[d] && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!rdy[d]) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout dut=%0d: o_ready never rose", d);
        end
        @(posedge clk);
        acc = cyc;
        #1;
        vld[d] = 1'b0;
        sblock = ~s; len = ~l; h = ~hh; ej0 = ~e; reft = ~r; mode = ~m; i_ch = ~c;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ovld[d] && lat < 300);
        if (!ovld[d]) begin
            n_checks++; n_fail++;
            $display("FAIL result_timeout dut=%0d: o_valid never rose", d);
        end
        tag = otag[d]; ok = aok[d]; fl = afail[d]; ch = och[d];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (ovld[d] !== 1'b0 || rdy[d] !== 1'b0 || otag[d] !== 128'd0 || och[d] !== 2'd0 ||
                aok[d] !== 1'b0 || afail[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state dut=%0d: valid=%b ready=%b tag=%h ch=%0d ok=%b fail=%b, want all 0",
                         d, ovld[d], rdy[d], otag[d], och[d], aok[d], afail[d]);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (rdy[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_release_ready dut=%0d: got %b want 1", d, rdy[d]);
            end
        end
    endtask

    task automatic test_tc1();
        logic [0:127] tag; logic ok, fl; logic [1:0] ch; int lat, acc; exp_t ex;
        sb.push_back('{tag: EJ0_C, ok: 1'b0, fail: 1'b0, ch: 2'd1, lat: 16});
        issue(0, 128'd0, 128'd0, H_C, EJ0_C, 128'd0, 1'b0, 2'd1, tag, ok, fl, ch, lat, acc);
        ex = sb.pop_front();
        n_checks++;
        if (tag !== ex.tag) begin
            n_fail++; $display("FAIL tc1_tag: got %h want %h", tag, ex.tag);
        end
        n_checks++;
        if (lat !== ex.lat) begin
            n_fail++; $display("FAIL tc1_latency: got %0d want %0d", lat, ex.lat);
        end
        n_checks++;
        if (ch !== ex.ch || ok !== ex.ok || fl !== ex.fail) begin
            n_fail++; $display("FAIL tc1_side: ch=%0d ok=%b fail=%b want ch=%0d ok=0 fail=0", ch, ok, fl, ex.ch);
        end
    endtask

    task automatic test_tc2_widths();
        logic [0:127] tag; logic ok, fl; logic [1:0] ch; int lat, acc; exp_t ex;
        for (int d = 0; d < 3; d++) begin
            sb.push_back('{tag: TAG2_C, ok: 1'b0, fail: 1'b0, ch: 2'(d), lat: lat_of[d]});
            issue(d, SB2_C, LEN2_C, H_C, EJ0_C, 128'd0, 1'b0, 2'(d), tag, ok, fl, ch, lat, acc);
            ex = sb.pop_front();
            n_checks++;
            if (tag !== ex.tag) begin
                n_fail++; $display("FAIL tc2_tag dut=%0d: got %h want %h", d, tag, ex.tag);
            end
            n_checks++;
            if (lat !== ex.lat) begin
                n_fail++; $display("FAIL tc2_latency dut=%0d: got %0d want %0d", d, lat, ex.lat);
            end
            n_checks++;
            if (ch !== ex.ch) begin
                n_fail++; $display("FAIL tc2_ch dut=%0d: got %0d want %0d", d, ch, ex.ch);
            end
        end
    endtask

    task automatic test_identity();
        logic [0:127] tag; logic ok, fl; logic [1:0] ch; int lat, acc; exp_t ex;
        sb.push_back('{tag: H_C, ok: 1'b0, fail: 1'b0, ch: 2'd2, lat: 16});
        issue(0, ONE_C, 128'd0, H_C, 128'd0, 128'd0, 1'b0, 2'd2, tag, ok, fl, ch, lat, acc);
        ex = sb.pop_front();
        n_checks++;
        if (tag !== ex.tag) begin
            n_fail++; $display("FAIL identity_tag: got %h want %h", tag, ex.tag);
        end
    endtask

    task automatic test_verify();
        logic [0:127] tag; logic ok, fl; logic [1:0] ch; int lat, acc; exp_t ex;
        logic [0:127] r;
        for (int k = 0; k < 3; k++) begin
            r = TAG2_C;
            if (k == 1) r[95] = ~r[95];
            if (k == 2) r[100] = ~r[100];
            sb.push_back('{tag: 128'd0, ok: (k != 1), fail: (k == 1), ch: 2'd0, lat: 16});
            issue(3, SB2_C, LEN2_C, H_C, EJ0_C, r, 1'b1, 2'd0, tag, ok, fl, ch, lat, acc);
            ex = sb.pop_front();
            n_checks++;
            if (ok !== ex.ok || fl !== ex.fail) begin
                n_fail++; $display("FAIL verify_flags case=%0d: ok=%b fail=%b want ok=%b fail=%b",
                                   k, ok, fl, ex.ok, ex.fail);
            end
            n_checks++;
            if (tag !== ex.tag) begin
                n_fail++; $display("FAIL verify_tag_hidden case=%0d: got %h want 0", k, tag);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [0:127] tag; logic ok, fl; logic [1:0] ch; int lat, acc; exp_t ex;
        irdy[0] = 1'b0;
        sb.push_back('{tag: TAG2_C, ok: 1'b0, fail: 1'b0, ch: 2'd3, lat: 16});
        issue(0, SB2_C, LEN2_C, H_C, EJ0_C, 128'd0, 1'b0, 2'd3, tag, ok, fl, ch, lat, acc);
        ex = sb.pop_front();
        n_checks++;
        if (tag !== ex.tag || ch !== ex.ch) begin
            n_fail++; $display("FAIL bp_result: tag=%h ch=%0d want %h ch=%0d", tag, ch, ex.tag, ex.ch);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (ovld[0] !== 1'b1 || otag[0] !== ex.tag || och[0] !== ex.ch || rdy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle=%0d: valid=%b tag=%h ch=%0d ready=%b want 1 %h %0d 0",
                         i, ovld[0], otag[0], och[0], rdy[0], ex.tag, ex.ch);
            end
        end
        irdy[0] = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (rdy[0] !== 1'b1 || ovld[0] !== 1'b0 || och[0] !== ex.ch || otag[0] !== ex.tag) begin
            n_fail++;
            $display("FAIL bp_release: ready=%b valid=%b ch=%0d tag=%h want 1 0 %0d %h",
                     rdy[0], ovld[0], och[0], otag[0], ex.ch, ex.tag);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [0:127] tag; logic ok, fl; logic [1:0] ch; int lat, acc; exp_t ex;
        logic seen;
        @(negedge clk);
        sblock = SB2_C; len = LEN2_C; h = H_C; ej0 = EJ0_C; mode = 1'b0; i_ch = 2'd1;
        vld[0] = 1'b1;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (ovld[0] !== 1'b0 || rdy[0] !== 1'b0 || otag[0] !== 128'd0) begin
            n_fail++; $display("FAIL midrst_assert: valid=%b ready=%b tag=%h want 0 0 0", ovld[0], rdy[0], otag[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (ovld[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            n_fail++; $display("FAIL midrst_release: valid=%b ready=%b want 0 1", ovld[0], rdy[0]);
        end
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ovld[0] === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL midrst_discard: o_valid rose after reset, want it to stay 0");
        end
        sb.push_back('{tag: TAG2_C, ok: 1'b0, fail: 1'b0, ch: 2'd2, lat: 16});
        issue(0, SB2_C, LEN2_C, H_C, EJ0_C, 128'd0, 1'b0, 2'd2, tag, ok, fl, ch, lat, acc);
        ex = sb.pop_front();
        n_checks++;
        if (tag !== ex.tag || lat !== ex.lat) begin
            n_fail++; $display("FAIL midrst_fresh: tag=%h lat=%0d want %h lat=%0d", tag, lat, ex.tag, ex.lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:127] tag; logic ok, fl; logic [1:0] ch; int lat, acc, prev; exp_t ex;
        logic [0:127] s, l, hh, e;
        logic [1:0] c;
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            s  = {$urandom, $urandom, $urandom, $urandom};
            l  = {$urandom, $urandom, $urandom, $urandom};
            hh = {$urandom, $urandom, $urandom, $urandom};
            e  = {$urandom, $urandom, $urandom, $urandom};
            c  = 2'($urandom_range(0, 3));
            sb.push_back('{tag: gmul(s ^ l, hh) ^ e, ok: 1'b0, fail: 1'b0, ch: c, lat: 16});
            issue(0, s, l, hh, e, 128'd0, 1'b0, c, tag, ok, fl, ch, lat, acc);
            ex = sb.pop_front();
            n_checks++;
            if (tag !== ex.tag || ch !== ex.ch) begin
                n_fail++; $display("FAIL b2b_result k=%0d: tag=%h ch=%0d want %h ch=%0d", k, tag, ch, ex.tag, ex.ch);
            end
            if (prev >= 0) begin
                n_checks++;
                if (acc - prev !== 18) begin
                    n_fail++; $display("FAIL b2b_interval k=%0d: got %0d cycles want 18", k, acc - prev);
                end
            end
            prev = acc;
        end
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            vld[d]  = 1'b0;
            irdy[d] = 1'b1;
        end
        sblock = 128'd0; len = 128'd0; h = H_C; ej0 = 128'd0; reft = 128'd0;
        mode = 1'b0; i_ch = 2'd0;
        test_reset();
        test_tc1();
        test_tc2_widths();
        test_identity();
        test_verify();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcm_tag_finalize.md
Name: gcm_tag_finalize

Overview:
Final-stage GCM tag engine: folds the length block into the running GHASH state, multiplies by H in GF(2^128), and XORs in E(K,J0) to form the tag. It is the successor to the fixed single-cycle tag stage. The GF multiplier is iterative with a parametrised slice width, so it trades latency for area. Adds a valid/ready handshake, channel tagging, tag truncation and a decrypt-verify mode. Sits after the last AES round / GHASH accumulate stage; output goes to the host result interface.

Parameters:
BITS_PER_CYCLE, 8, multiplier bits of X consumed per cycle; must divide 128 (1,2,4,8,16,32,64,128); N = 128/BITS_PER_CYCLE
NUM_CH, 4, number of channel IDs carried as sideband; CHW = max(1,clog2(NUM_CH))
TAG_BYTES, 16, tag length in bytes, legal 12..16

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_valid  in  1  request valid
o_ready  out  1  block can accept a request
i_ch  in  CHW  channel ID of request
i_sblock  in  128  GHASH state before length block, bit [0] = MSB
i_instance_size  in  128  len(A)||len(C) block
i_h  in  128  hash subkey H
i_encrypted_j0  in  128  E(K,J0)
i_mode  in  1  0 = generate tag (encrypt), 1 = verify tag (decrypt)
i_ref_tag  in  128  received tag for verify; only bits [0:8*TAG_BYTES-1] used
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_ch  out  CHW  channel ID of result
o_tag  out  128  computed tag, truncated
o_auth_ok  out  1  verify mode: tags match
o_auth_fail  out  1  verify mode: tags differ

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on rst. Everything is one clock domain.
- Reset values: state IDLE; o_valid=0; o_tag=0; o_ch=0; o_auth_ok=0; o_auth_fail=0; all internal registers 0.
- o_ready = (state==IDLE) & ~rst.
- FSM states and transitions:
  - IDLE: a request is accepted on i_valid & o_ready at a clock edge. On acceptance, latch X = i_sblock ^ i_instance_size, V = i_h, Z = 0, E = i_encrypted_j0, mode, ref tag and ch. Set count = 0 and go to MUL.
  - MUL: each cycle processes BITS_PER_CYCLE bits of X, MSB first. For each bit X[i]: if X[i]=1, Z ^= V. Then V = V>>1 (toward higher index); if the old V[127]=1, V ^= R, where R = 0xE1 followed by 120 zeros. count increments each cycle. After the N-th cycle the block goes to DONE and registers the result as follows:
    - T = Z ^ E.
    - o_tag[0:8*TAG_BYTES-1] = T[0:8*TAG_BYTES-1]; remaining o_tag bits are 0.
    - In verify mode o_tag is forced to all zero (the expected tag is not leaked).
    - o_auth_ok = mode & (T[0:8*TAG_BYTES-1] == ref[0:8*TAG_BYTES-1]).
    - o_auth_fail = mode & ~match.
    - In encrypt mode both auth flags are 0.
  - DONE: o_valid=1. All outputs are held stable until i_ready=1. On the edge where o_valid & i_ready, go to IDLE, clear o_valid and both auth flags; o_tag and o_ch hold their values.
- Latency: accept edge T0 -> o_valid high after edge T0+N (16 cycles at default).
- Throughput: one request per N+2 cycles when i_ready is held high.
- No back-to-back accept in DONE: o_ready stays 0 until IDLE is reached.
- i_valid while busy is ignored; the requester must hold it until accepted.
- i_* data is sampled only at the accept edge; later changes have no effect on the result in flight.
- Reset mid-operation (MUL or DONE): the result is discarded, outputs return to reset values immediately, and the block comes back in IDLE.
- BITS_PER_CYCLE=128 gives N=1: one MUL cycle, fully unrolled product.
- Invalid parameters (a BITS_PER_CYCLE that does not divide 128, or TAG_BYTES outside 12..16) cause an elaboration-time error.

Test Plan:
- GCM test case 1:
  - Stimulus: sblock=0, len=0, H=66e94bd4ef8a2c3b884cfa59ca342b2e, ej0=58e2fccefa7e3061367f1d57a4e7455a, mode=0.
  - Required: o_tag=58e2fccefa7e3061367f1d57a4e7455a, o_valid exactly 16 cycles after accept.
- GCM test case 2:
  - Stimulus: sblock=5e2ec746917062882c85b0685353deb7, len=00000000000000000000000000000080, same H and ej0.
  - Required: o_tag=ab6e47d42cec13bdf53a67b21257bddf.
  - Repeat with BITS_PER_CYCLE in {1,8,128}: same tag, with latency 128 / 16 / 1.
- Multiplier identity:
  - Stimulus: sblock=80000000000000000000000000000000, len=0, ej0=0.
  - Required: o_tag = H.
- Verify mode:
  - Stimulus: test case 2 with i_ref_tag=ab6e47d4..., TAG_BYTES=12.
  - Required: o_auth_ok=1, o_auth_fail=0, o_tag=0.
  - Flip ref bit 95 -> o_auth_fail=1. Flip ref bit 100 -> still ok (truncated bits ignored).
- Backpressure:
  - Stimulus: hold i_ready=0 for 10 cycles after o_valid, with i_ch=3.
  - Required: o_valid, o_tag and o_ch=3 stay stable; o_ready=0 throughout. o_ready=1 one cycle after the handshake.
- Reset mid-MUL:
  - Stimulus: assert rst at count=5 and release.
  - Required: o_valid=0 and o_ready=1 after release. A fresh test-case-2 request then gives the correct tag.
